// File: rtl/perf_mon_pkg.sv
// perf_mon_pkg: shared FSM state type and counter-index helpers for the
// performance event monitor.
package perf_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } mon_state_t;

  // Counter slots 0..NUM_CH-1 are event channels; the cycle and retire
  // counters follow immediately after.
  function automatic int unsigned cyc_idx(input int unsigned num_ch);
    return num_ch;
  endfunction

  function automatic int unsigned ret_idx(input int unsigned num_ch);
    return num_ch + 1;
  endfunction

  function automatic int unsigned num_cnt(input int unsigned num_ch);
    return num_ch + 2;
  endfunction

endpackage

// File: rtl/perf_ctr.sv
// perf_ctr: one event counter with enable, synchronous clear and a sticky
// overflow flag. Saturates at all-ones by default; wraps to zero when
// PERF_MON_WRAP_EN is defined.
module perf_ctr #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  // Count on enable; clear wins over enable; overflow is sticky until clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (&cnt) begin
        ovf <= 1'b1;
`ifdef PERF_MON_WRAP_EN
        cnt <= '0;
`endif
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_event_monitor.sv
// perf_event_monitor: bank of NUM_CH event counters plus cycle and retire
// counters, gated by an IDLE/RUN/HALTED FSM, with a registered read port.
// Optional build macro: PERF_MON_WRAP_EN (counters wrap instead of saturate).
module perf_event_monitor
  import perf_mon_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned SEL_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              retire_i,
  input  logic              halt_i,
  input  logic              rd_req_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic              rd_valid_o,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic              rd_err_o,
  output logic [1:0]        state_o,
  output logic [NUM_CH+1:0] ovf_o
);

  localparam int unsigned CYC_IDX = cyc_idx(NUM_CH);
  localparam int unsigned RET_IDX = ret_idx(NUM_CH);
  localparam int unsigned NUM_CNT = num_cnt(NUM_CH);

  mon_state_t            state;
  logic                  run;
  logic [NUM_CNT-1:0]    cnt_en;
  logic [CNT_W-1:0]      cnt [NUM_CNT];
  logic [CNT_W-1:0]      rd_mux;
  logic                  rd_in_range;

  // FSM: clear has priority everywhere; HALTED is left only by clear/reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else if (clear_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start_i) state <= ST_RUN;
        ST_RUN:    if (halt_i)  state <= ST_HALTED;
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign run     = (state == ST_RUN);
  assign state_o = state;

  // Per-counter enables; clear suppresses counting in the same cycle via perf_ctr.
  always_comb begin
    cnt_en                 = '0;
    cnt_en[NUM_CH-1:0]     = event_i & {NUM_CH{run}};
    cnt_en[CYC_IDX]        = run;
    cnt_en[RET_IDX]        = retire_i & run;
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_ctr
    perf_ctr #(
      .CNT_W (CNT_W)
    ) u_ctr (
      .clk (clk),
      .rst (rst),
      .en  (cnt_en[g]),
      .clr (clear_i),
      .cnt (cnt[g]),
      .ovf (ovf_o[g])
    );
  end

  // Select the addressed counter; out-of-range selects read as zero.
  always_comb begin
    rd_mux      = '0;
    rd_in_range = 1'b0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (32'(rd_sel_i) == i) begin
        rd_mux      = cnt[i];
        rd_in_range = 1'b1;
      end
    end
  end

  // Read response register: snapshot taken before this edge's increments,
  // data/err hold between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      rd_err_o   <= 1'b0;
    end else begin
      rd_valid_o <= rd_req_i;
      if (rd_req_i) begin
        rd_data_o <= rd_mux;
        rd_err_o  <= ~rd_in_range;
      end
    end
  end

endmodule

// File: tb/tb_perf_event_monitor.sv
// tb_perf_event_monitor: directed self-checking bench for perf_event_monitor.
// A second 8-bit instance exercises saturation/wrap (PERF_MON_WRAP_EN).
module tb_perf_event_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start = 0, clear = 0, retire = 0, halt = 0, rd_req = 0;
  logic [3:0]  ev = '0;
  logic [4:0]  rd_sel = '0;
  logic        rd_valid, rd_err;
  logic [31:0] rd_data;
  logic [1:0]  state;
  logic [5:0]  ovf;

  logic        start8 = 0, clear8 = 0, retire8 = 0, halt8 = 0, rd_req8 = 0;
  logic [3:0]  ev8 = '0;
  logic [4:0]  rd_sel8 = '0;
  logic        rd_valid8, rd_err8;
  logic [7:0]  rd_data8;
  logic [1:0]  state8;
  logic [5:0]  ovf8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  perf_event_monitor #(.NUM_CH(4), .CNT_W(32), .SEL_W(5)) dut (
    .clk(clk), .rst(rst), .start_i(start), .clear_i(clear), .event_i(ev),
    .retire_i(retire), .halt_i(halt), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_err_o(rd_err),
    .state_o(state), .ovf_o(ovf)
  );

  perf_event_monitor #(.NUM_CH(4), .CNT_W(8), .SEL_W(5)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .clear_i(clear8), .event_i(ev8),
    .retire_i(retire8), .halt_i(halt8), .rd_req_i(rd_req8), .rd_sel_i(rd_sel8),
    .rd_valid_o(rd_valid8), .rd_data_o(rd_data8), .rd_err_o(rd_err8),
    .state_o(state8), .ovf_o(ovf8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Single read on the 32-bit instance; called at a negedge, returns at the
  // negedge where the response is visible.
  task automatic rd(input logic [4:0] sel, input logic [31:0] exp, input logic exp_err,
                    input string tag);
    rd_req = 1'b1;
    rd_sel = sel;
    @(negedge clk);
    rd_req = 1'b0;
    chk({tag, "_valid"}, 64'(rd_valid), 64'(1));
    chk({tag, "_data"}, 64'(rd_data), 64'(exp));
    chk({tag, "_err"}, 64'(rd_err), 64'(exp_err));
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_valid", 64'(rd_valid), 64'(0));
    chk("rst_data", 64'(rd_data), 64'(0));
    chk("rst_err", 64'(rd_err), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Start cycle carries events that must not be counted
    start = 1'b1;
    ev = 4'b0101;
    @(negedge clk);
    start = 1'b0;
    chk("run_state", 64'(state), 64'(1));
    for (int i = 0; i < 10; i++) begin
      ev = 4'b0101;
      retire = (i == 0 || i == 4 || i == 7);
      @(negedge clk);
    end
    // Halt cycle is counted
    halt = 1'b1;
    retire = 1'b0;
    @(negedge clk);
    halt = 1'b0;
    ev = '0;
    chk("halt_state", 64'(state), 64'(2));
    rd(5'd0, 32'd11, 1'b0, "ch0");
    rd(5'd2, 32'd11, 1'b0, "ch2");
    rd(5'd1, 32'd0, 1'b0, "ch1");
    rd(5'd4, 32'd11, 1'b0, "cyc");
    rd(5'd5, 32'd3, 1'b0, "ret");

    // Activity while HALTED is ignored
    for (int i = 0; i < 20; i++) begin
      ev = (i % 2 == 1) ? 4'hF : 4'h0;
      retire = (i % 2 == 1);
      start = (i == 3);
      halt = (i == 5);
      @(negedge clk);
    end
    ev = '0; retire = 0; start = 0; halt = 0;
    chk("frz_state", 64'(state), 64'(2));
    rd(5'd0, 32'd11, 1'b0, "frz_ch0");
    rd(5'd1, 32'd0, 1'b0, "frz_ch1");
    rd(5'd3, 32'd0, 1'b0, "frz_ch3");
    rd(5'd4, 32'd11, 1'b0, "frz_cyc");
    rd(5'd5, 32'd3, 1'b0, "frz_ret");

    // 8-bit instance: 300 events on ch1 (last one in the halt cycle)
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ev8 = 4'b0010;
    repeat (299) @(negedge clk);
    halt8 = 1'b1;
    @(negedge clk);
    halt8 = 1'b0;
    ev8 = '0;
    chk("w8_state", 64'(state8), 64'(2));
    rd_req8 = 1'b1;
    rd_sel8 = 5'd1;
    @(negedge clk);
    rd_req8 = 1'b0;
    chk("w8_valid", 64'(rd_valid8), 64'(1));
`ifdef PERF_MON_WRAP_EN
    chk("w8_ch1", 64'(rd_data8), 64'(44));
`else
    chk("w8_ch1", 64'(rd_data8), 64'(255));
`endif
    chk("w8_ovf1", 64'(ovf8[1]), 64'(1));
    chk("w8_ovf0", 64'(ovf8[0]), 64'(0));

    // Clear with start, events and a coincident read; read sees pre-clear value
    clear = 1'b1; start = 1'b1; ev = 4'hF; rd_req = 1'b1; rd_sel = 5'd0;
    clear8 = 1'b1; start8 = 1'b1; ev8 = 4'hF;
    @(negedge clk);
    clear = 0; start = 0; ev = '0; rd_req = 0;
    clear8 = 0; start8 = 0; ev8 = '0;
    chk("clr_rd_valid", 64'(rd_valid), 64'(1));
    chk("clr_rd_data", 64'(rd_data), 64'(11));
    chk("clr_state", 64'(state), 64'(0));
    chk("clr_ovf", 64'(ovf), 64'(0));
    chk("clr_state8", 64'(state8), 64'(0));
    chk("clr_ovf8", 64'(ovf8), 64'(0));
    for (int s = 0; s < 6; s++) begin
      rd(5'(s), 32'd0, 1'b0, "clr_rd");
    end

    // Back-to-back reads: ch0, retire, out-of-range
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ev = 4'b0001; retire = 1'b1;
    @(negedge clk);
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 0; ev = '0; retire = 0;
    rd_req = 1'b1; rd_sel = 5'd0;
    @(negedge clk);
    chk("b2b0_valid", 64'(rd_valid), 64'(1));
    chk("b2b0_data", 64'(rd_data), 64'(3));
    chk("b2b0_err", 64'(rd_err), 64'(0));
    rd_sel = 5'd5;
    @(negedge clk);
    chk("b2b1_valid", 64'(rd_valid), 64'(1));
    chk("b2b1_data", 64'(rd_data), 64'(3));
    chk("b2b1_err", 64'(rd_err), 64'(0));
    rd_sel = 5'd31;
    @(negedge clk);
    rd_req = 1'b0;
    chk("b2b2_valid", 64'(rd_valid), 64'(1));
    chk("b2b2_data", 64'(rd_data), 64'(0));
    chk("b2b2_err", 64'(rd_err), 64'(1));
    @(negedge clk);
    chk("b2b_idle_valid", 64'(rd_valid), 64'(0));
    chk("b2b_hold_data", 64'(rd_data), 64'(0));

    // Asynchronous reset mid-RUN with a read response pending
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ev = 4'b0101;
    repeat (3) @(negedge clk);
    rd_req = 1'b1; rd_sel = 5'd2;
    @(posedge clk);
    #1;
    chk("ar_pend_valid", 64'(rd_valid), 64'(1));
    chk("ar_pend_data", 64'(rd_data), 64'(3));
    #1;
    rst = 1'b0;
    rd_req = 1'b0;
    ev = '0;
    #1;
    chk("ar_valid", 64'(rd_valid), 64'(0));
    chk("ar_data", 64'(rd_data), 64'(0));
    chk("ar_state", 64'(state), 64'(0));
    chk("ar_ovf", 64'(ovf), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ar_no_pulse", 64'(rd_valid), 64'(0));
    end
    rd(5'd2, 32'd0, 1'b0, "ar_ch2");
    rd(5'd4, 32'd0, 1'b0, "ar_cyc");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
